// File: rtl/perf_event_monitor.sv
// Pipeline performance event monitor: a saturating cycle counter plus NUM_EVT
// saturating event counters. Provides a programmable cycle limit, pause/resume,
// an atomic snapshot into a shadow bank, and registered indexed readout.
module perf_event_monitor #(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned LIMIT_W = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           clear_i,
  input  logic [LIMIT_W-1:0]             limit_i,
  input  logic [NUM_EVT-1:0]             evt_i,
  input  logic                           snap_i,
  input  logic [$clog2(NUM_EVT+1)-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]               rd_data_o,
  output logic                           running_o,
  output logic                           done_o,
  output logic [NUM_EVT:0]               ovf_o
);

  localparam int unsigned NCH   = NUM_EVT + 1;
  localparam int unsigned SEL_W = $clog2(NCH);
  localparam int unsigned CMP_W = (CNT_W > LIMIT_W) ? CNT_W : LIMIT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_EVT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [NCH-1:0][CNT_W-1:0]  live_q, live_d;
  logic [NCH-1:0][CNT_W-1:0]  shadow_q, shadow_d;
  logic [NCH-1:0]             ovf_q, ovf_d;
  logic [LIMIT_W-1:0]         limit_q, limit_d;
  logic [CNT_W-1:0]           rd_data_q, rd_data_d;
  logic                       running_q, done_q;
  logic [NCH-1:0]             inc;
  logic [CNT_W-1:0]           cyc_next;

  // Next-state: clear beats the FSM; snapshot and readout work in every state.
  always_comb begin
    state_d   = state_q;
    live_d    = live_q;
    shadow_d  = shadow_q;
    ovf_d     = ovf_q;
    limit_d   = limit_q;
    rd_data_d = '0;
    inc       = {evt_i, 1'b1};
    cyc_next  = (live_q[0] == CNT_MAX) ? CNT_MAX : live_q[0] + 1'b1;

    // Readout sees the shadow bank as it was before this edge.
    if (rd_sel_i <= SEL_MAX) begin
      rd_data_d = shadow_q[rd_sel_i];
    end

    // Snapshot captures pre-increment, pre-clear live values.
    if (snap_i) begin
      shadow_d = live_q;
    end

    if (clear_i) begin
      live_d  = '0;
      ovf_d   = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
            limit_d = limit_i;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < int'(NCH); k++) begin
            if (inc[k]) begin
              if (live_q[k] == CNT_MAX) begin
                ovf_d[k] = 1'b1;
              end else begin
                live_d[k] = live_q[k] + 1'b1;
              end
            end
          end
          // Limit reached takes precedence over a simultaneous pause request.
          if ((limit_q != '0) && (CMP_W'(cyc_next) == CMP_W'(limit_q))) begin
            state_d = ST_DONE;
          end else if (!start_i) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_i) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      live_q    <= '0;
      shadow_q  <= '0;
      ovf_q     <= '0;
      limit_q   <= '0;
      rd_data_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      shadow_q  <= shadow_d;
      ovf_q     <= ovf_d;
      limit_q   <= limit_d;
      rd_data_q <= rd_data_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign rd_data_o = rd_data_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Scoreboard bench for perf_event_monitor: directed stimulus pushes expected
// post-edge values tagged with the cycle they are due; a monitor pops and compares.
module tb_perf_event_monitor;

  localparam int K_RD   = 0;
  localparam int K_RUN  = 1;
  localparam int K_DONE = 2;
  localparam int K_OVF  = 3;
  localparam int K_RD4  = 4;
  localparam int K_OVF4 = 5;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] limit = '0;
  logic [3:0]  evt = '0;
  logic        snap = 1'b0;
  logic [2:0]  rd_sel = '0;

  logic [31:0] rd_data;
  logic        running, done;
  logic [4:0]  ovf;
  logic [3:0]  rd_data4;
  logic        running4, done4;
  logic [4:0]  ovf4;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(32), .LIMIT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit),
    .evt_i(evt), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .running_o(running), .done_o(done), .ovf_o(ovf)
  );

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(4), .LIMIT_W(16)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit),
    .evt_i(evt), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_data4),
    .running_o(running4), .done_o(done4), .ovf_o(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: just after each edge, compare every entry due on this cycle.
  always @(posedge clk) begin
    exp_t        e;
    logic [31:0] act;
    #1;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    act = rd_data;
        K_RUN:   act = 32'(running);
        K_DONE:  act = 32'(done);
        K_OVF:   act = 32'(ovf);
        K_RD4:   act = 32'(rd_data4);
        K_OVF4:  act = 32'(ovf4);
        default: act = 32'hDEAD_BEEF;
      endcase
      vectors++;
      if (e.due != cyc || act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %0d required %0d (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected value of an output after the next rising edge.
  task automatic push_exp(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [2:0] sel, input logic [31:0] val, input string name);
    rd_sel = sel;
    push_exp(K_RD, val, name);
    tick();
  endtask

  task automatic rd4(input logic [2:0] sel, input logic [31:0] val, input string name);
    rd_sel = sel;
    push_exp(K_RD4, val, name);
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    push_exp(K_RUN,  0, {tag, "_rst_run"});
    push_exp(K_DONE, 0, {tag, "_rst_done"});
    push_exp(K_OVF,  0, {tag, "_rst_ovf"});
    push_exp(K_RD,   0, {tag, "_rst_rd"});
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();

    // 1: limit 10, done after 10 counted RUN edges, then frozen
    rst_all_inputs();
    do_reset("t1");
    limit = 16'd10; start = 1'b1; evt = 4'b0001;
    push_exp(K_RUN, 1, "t1_running");
    tick();
    repeat (8) tick();
    push_exp(K_DONE, 0, "t1_done_early");
    tick();
    push_exp(K_DONE, 1, "t1_done");
    push_exp(K_RUN,  0, "t1_stopped");
    tick();
    repeat (3) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    rd(3'd0, 10, "t1_cycles");
    rd(3'd1, 10, "t1_evt0");
    rd(3'd2, 0,  "t1_evt1");
    push_exp(K_DONE, 1, "t1_done_sticky");
    tick();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL t1_direct_done: got %0d required 1", done);
    end
    vectors++;
    if (running !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_direct_running: got %0d required 0", running);
    end

    // 2: pause/resume, PAUSE counts nothing, transition edges into PAUSE count
    rst_all_inputs();
    do_reset("t2");
    limit = 16'd0; evt = 4'b0010; start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    push_exp(K_RUN, 0, "t2_paused");
    tick();
    tick();
    snap = 1'b1; tick(); snap = 1'b0;
    start = 1'b1; rd_sel = 3'd0;
    push_exp(K_RD, 5, "t2_pause_cycles");
    push_exp(K_RUN, 1, "t2_resumed");
    tick();
    rd_sel = 3'd2;
    push_exp(K_RD, 5, "t2_pause_evt1");
    tick();
    repeat (2) tick();
    start = 1'b0; tick();
    snap = 1'b1; tick(); snap = 1'b0;
    rd(3'd0, 9, "t2_cycles");
    rd(3'd2, 9, "t2_evt1");
    rd(3'd1, 0, "t2_evt0");

    // 3: 4-bit counters saturate, ovf sticky until clear, shadow survives clear
    rst_all_inputs();
    do_reset("t3");
    limit = 16'd0; evt = 4'b0000; start = 1'b1;
    repeat (15) tick();
    push_exp(K_OVF4, 0, "t3_ovf_at_max");
    tick();
    push_exp(K_OVF4, 1, "t3_ovf_set");
    tick();
    repeat (3) tick();
    start = 1'b0;
    push_exp(K_OVF, 0, "t3_wide_no_ovf");
    tick();
    snap = 1'b1; tick(); snap = 1'b0;
    rd4(3'd0, 15, "t3_sat_cycles");
    rd4(3'd1, 0,  "t3_sat_evt0");
    clear = 1'b1;
    push_exp(K_OVF4, 0, "t3_clear_ovf");
    tick();
    clear = 1'b0;
    vectors++;
    if (ovf4 !== 5'd0) begin
      miscompares++;
      $display("FAIL t3_direct_ovf_cleared: got %0d required 0", ovf4);
    end
    rd4(3'd0, 15, "t3_shadow_kept");
    snap = 1'b1; tick(); snap = 1'b0;
    rd4(3'd0, 0, "t3_cleared_live");

    // 4: snap with same-edge event, snap+read, snap+clear
    rst_all_inputs();
    do_reset("t4");
    limit = 16'd0; start = 1'b1; evt = 4'b0100;
    repeat (8) tick();
    snap = 1'b1; tick();
    start = 1'b0; rd_sel = 3'd3;
    push_exp(K_RD, 7, "t4_snap_pre_inc");
    tick();
    snap = 1'b0;
    rd(3'd3, 8, "t4_live_after_inc");
    snap = 1'b1; clear = 1'b1; rd_sel = 3'd0;
    push_exp(K_RD,   8, "t4_cycles_old_shadow");
    push_exp(K_RUN,  0, "t4_clear_run");
    push_exp(K_DONE, 0, "t4_clear_done");
    tick();
    snap = 1'b0; clear = 1'b0;
    rd(3'd3, 9, "t4_snap_clear_evt2");
    rd(3'd0, 9, "t4_snap_clear_cycles");
    snap = 1'b1; tick(); snap = 1'b0;
    rd(3'd3, 0, "t4_live_zero");

    // 5: reset mid-run with start held; limit re-latched on restart
    rst_all_inputs();
    do_reset("t5");
    limit = 16'd30; start = 1'b1; evt = 4'b1111;
    tick();
    repeat (22) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    do_reset("t5_mid");
    limit = 16'd3; rd_sel = 3'd0;
    push_exp(K_RUN, 1, "t5_rerun");
    push_exp(K_RD,  0, "t5_shadow_reset");
    tick();
    tick();
    push_exp(K_DONE, 0, "t5_done_early");
    tick();
    push_exp(K_DONE, 1, "t5_new_limit");
    push_exp(K_RUN,  0, "t5_stopped");
    tick();
    snap = 1'b1; tick(); snap = 1'b0;
    rd(3'd0, 3, "t5_cycles");
    rd(3'd4, 3, "t5_evt3");
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL t5_direct_done: got %0d required 1", done);
    end

    // 6: out-of-range indices read zero; one-cycle read latency
    rd(3'd5, 0, "t6_sel5");
    rd(3'd1, 3, "t6_sel1");
    rd(3'd5, 0, "t6_sel5_again");
    rd(3'd7, 0, "t6_sel7");
    rd(3'd2, 3, "t6_sel2");

    repeat (3) tick();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never compared (due %0d, now %0d)", e.name, e.due, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic rst_all_inputs();
    start  = 1'b0;
    clear  = 1'b0;
    snap   = 1'b0;
    evt    = '0;
    rd_sel = '0;
  endtask

endmodule
